// File: rtl/video_timing_gen.sv
// Raster timing generator: walks an h/v counter pair over the full frame, pulls
// pixels from a 1-cycle-latency read FIFO and drives a fully registered video port.
module video_timing_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] FILL_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  video_vsync,
  output logic                  video_hsync,
  output logic                  video_de,
  output logic [DATA_WIDTH-1:0] video_data,
  output logic                  frame_start,
  output logic [15:0]           underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // enable is only honoured on the last cycle of a frame, so frames are never cut short
  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;
    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_next = '0;
          if (v_cnt == V_LAST) begin
            v_next = '0;
            if (!enable) state_next = IDLE;
          end else begin
            v_next = v_cnt + 10'd1;
          end
        end else begin
          h_next = h_cnt + 11'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic running, active, hs, vs, first_px;

  assign running    = (state == RUN);
  assign active     = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs         = running && (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs         = running && (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  assign first_px   = active && (h_cnt == '0) && (v_cnt == '0);
  assign fifo_rd_en = active && !fifo_empty;

  logic de_d1, hs_d1, vs_d1, fs_d1, rd_en_d1, run_d1;

  // First stage waits out the FIFO read latency; second stage registers the port.
  // Blanking in RUN carries the fill colour, IDLE drives data low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d1       <= 1'b0;
      hs_d1       <= 1'b0;
      vs_d1       <= 1'b0;
      fs_d1       <= 1'b0;
      rd_en_d1    <= 1'b0;
      run_d1      <= 1'b0;
      video_de    <= 1'b0;
      video_hsync <= 1'b0;
      video_vsync <= 1'b0;
      frame_start <= 1'b0;
      video_data  <= '0;
    end else begin
      de_d1       <= active;
      hs_d1       <= hs;
      vs_d1       <= vs;
      fs_d1       <= first_px;
      rd_en_d1    <= fifo_rd_en;
      run_d1      <= running;
      video_de    <= de_d1;
      video_hsync <= hs_d1;
      video_vsync <= vs_d1;
      frame_start <= fs_d1;
      video_data  <= rd_en_d1 ? fifo_rd_data : (run_d1 ? FILL_COLOR : '0);
    end
  end

  // Starved pixels are skipped rather than re-fetched so lines stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (active && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a small raster keeps run time short,
// a linear-position reference model feeds a 2-deep expected-output scoreboard.
module tb_video_timing_gen;

  localparam int HA = 64, HFP = 1, HSW = 2, HBP = 1;
  localparam int VA = 32, VFP = 1, VSW = 1, VBP = 1;
  localparam int DW = 24;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [DW-1:0] FILL = 24'hABCDEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable, fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rd_data, video_data;
  logic          video_vsync, video_hsync, video_de, frame_start;
  logic [15:0]   underflow_cnt;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          mpos, mpix, fifo_pix;
  logic        mrun, dropped;
  logic [15:0] mcnt;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .DATA_WIDTH(DW), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .video_vsync(video_vsync),
    .video_hsync(video_hsync),
    .video_de(video_de),
    .video_data(video_data),
    .frame_start(frame_start),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, expv, $time);
    end
    if (failures >= 50) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  // Outputs seen now belong to the counter state two cycles back
  task automatic checkOutput();
    exp_t e;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_underrun observed=0 expected=nonzero");
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checkEq("video_de", video_de, e.de);
    checkEq("video_hsync", video_hsync, e.hs);
    checkEq("video_vsync", video_vsync, e.vs);
    checkEq("frame_start", frame_start, e.fs);
    checkEq("video_data", video_data, e.data);
    checkEq("underflow_cnt", underflow_cnt, mcnt);
  endtask

  // One clock cycle: drive inputs, check, model this cycle, then act as the FIFO
  task automatic applyStimulus(input logic en_i, input logic emp_i);
    exp_t e;
    logic act, rd, dut_rd;
    int   h, v;
    enable     = en_i;
    fifo_empty = emp_i;
    #1;
    checkOutput();
    h      = mpos % HT;
    v      = mpos / HT;
    act    = mrun && (h < HA) && (v < VA);
    rd     = act && !emp_i;
    e.de   = act;
    e.hs   = mrun && (h >= HA + HFP) && (h < HA + HFP + HSW);
    e.vs   = mrun && (v >= VA + VFP) && (v < VA + VFP + VSW);
    e.fs   = act && (mpos == 0);
    e.data = rd ? DW'(mpix) : (mrun ? FILL : '0);
    exp_q.push_back(e);
    checkEq("fifo_rd_en", fifo_rd_en, rd);
    if (rd) mpix++;
    if (act && emp_i && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    if (!mrun) begin
      if (en_i) begin
        mrun = 1'b1;
        mpos = 0;
      end
    end else if (mpos == FRAME - 1) begin
      mpos = 0;
      if (!en_i) mrun = 1'b0;
    end else begin
      mpos++;
    end
    dut_rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (dut_rd) begin
      fifo_rd_data = DW'(fifo_pix);
      fifo_pix++;
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkEq("rst_de", video_de, 0);
    checkEq("rst_hsync", video_hsync, 0);
    checkEq("rst_vsync", video_vsync, 0);
    checkEq("rst_frame_start", frame_start, 0);
    checkEq("rst_data", video_data, 0);
    checkEq("rst_rd_en", fifo_rd_en, 0);
    checkEq("rst_underflow", underflow_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    mrun = 1'b0;
    mpos = 0;
    mcnt = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  initial begin
    enable       = 1'b0;
    fifo_empty   = 1'b0;
    fifo_rd_data = '0;
    fifo_pix     = 0;
    mpix         = 0;
    mpos         = 0;
    mrun         = 1'b0;
    mcnt         = '0;
    dropped      = 1'b0;
    @(negedge clk);
    applyReset();
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Frame 0: streaming data, 10-pixel starvation at line 3 px 10, enable dropped at line 10
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < FRAME + 20; i++) begin
      if (mrun && (mpos / HT) == 10) dropped = 1'b1;
      applyStimulus(!dropped, mrun && (mpos / HT) == 3 && (mpos % HT) >= 10 && (mpos % HT) < 20);
    end
    checkEq("underflow_after_burst", underflow_cnt, 10);
    checkEq("pixels_read_frame0", fifo_pix, HA * VA - 10);

    // Restart with the FIFO permanently empty until the counter saturates
    for (int i = 0; i < 90000 && mcnt != 16'hFFFF; i++) applyStimulus(1'b1, 1'b1);
    checkEq("underflow_saturated", underflow_cnt, 16'hFFFF);
    repeat (200) applyStimulus(1'b1, 1'b1);

    // Run on to line 20 pixel 30 with data flowing, then reset mid-frame
    for (int i = 0; i < 2 * FRAME && !(mrun && mpos == 20 * HT + 30); i++)
      applyStimulus(1'b1, 1'b0);
    checkEq("pixels_before_reset", fifo_pix, HA * VA - 10 + 20 * HA + 30);
    applyReset();
    repeat (20) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (3 * HT) applyStimulus(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
